cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single writeback (common data bus) port between the execution units.
- That port drives wd/wr/w_tag into the ID stage register file and the reservation stations.
- Each EX unit hands a finished result (value, destination register, ROB tag) to a one-entry holding buffer. A round-robin scheduler broadcasts one buffered result per cycle through a registered output.
- A synchronous flush discards all in-flight results on mispredict/exception recovery.

Parameters:
- EX_NUM, 4, number of requesting execution units (matches EX_UNIT_NUM)
- DATA_W, 32, result width (COMMON_LENGTH)
- REG_W, 5, register index width
- TAG_W, 4, ROB tag width; tag value 0 is reserved for "no tag / no broadcast"

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous discard of all buffered and outgoing results
- req_valid  input  EX_NUM  per-unit result-valid
- req_ready  output  EX_NUM  per-unit buffer can accept this cycle
- req_data  input  EX_NUM*DATA_W  per-unit result value; unit i occupies bits [i*DATA_W +: DATA_W]
- req_reg  input  EX_NUM*REG_W  per-unit destination register
- req_tag  input  EX_NUM*TAG_W  per-unit ROB tag
- wb_valid  output  1  broadcast valid this cycle
- wd  output  DATA_W  broadcast value
- wr  output  REG_W  broadcast destination register
- w_tag  output  TAG_W  broadcast ROB tag; 0 whenever wb_valid=0
- grant_id  output  log2(EX_NUM)  index of the unit whose result is on the bus; 0 when idle

Behaviour:
- Reset (async, immediate): all buf_valid=0, rr_ptr=0.
- Outputs during reset: wb_valid=0, wd=0, wr=0, w_tag=0, grant_id=0. req_ready is all ones after reset release.
- Holding buffer i: fields buf_valid, buf_data, buf_reg, buf_tag.
  - req_ready[i] = !flush && (!buf_valid[i] || grant[i]). Combinational; the buffer may refill in the same cycle it is drained.
  - Accept on req_valid[i] && req_ready[i] at the clock edge: the buffer loads the request fields and sets buf_valid[i]=1.
  - req_valid with tag 0 is illegal. The buffer must ignore it: no load, no broadcast.
- Scheduler (combinational, each cycle):
  - Scan buf_valid starting at rr_ptr, wrapping modulo EX_NUM. The first valid index is granted. At most one grant per cycle.
  - On a grant to i: clear buf_valid[i], unless it is reloaded in the same edge. Set rr_ptr=(i+1) mod EX_NUM.
  - No grant: rr_ptr is held.
- Output register: at each edge, load wb_valid=|grant together with the granted buffer's data/reg/tag and grant_id.
  - With no grant, load wb_valid=0, w_tag=0, wd=0, wr=0.
  - Each broadcast is one cycle wide. The bus never stalls, because the register file and stations always accept.
- Latency: a request accepted at edge E0 with no contention appears on wd/wr/w_tag after edge E1. The worst case with all EX_NUM buffers full is EX_NUM edges after acceptance.
- Throughput: 1 result/cycle sustained. A single unit requesting every cycle gets every cycle.
- Fairness: once a buffer is valid, it is granted within EX_NUM cycles.
- Flush (sync, highest priority): at the edge, all buf_valid=0 and wb_valid=0, w_tag=0, wd=0, wr=0, grant_id=0. req_ready=0 during the flush cycle, so nothing is accepted. rr_ptr is held.
- Simultaneous events:
  - Refill and grant on the same unit in one edge: the new result is captured and the old one is broadcast.
  - Reset asserted mid-broadcast: outputs clear immediately, with no partial broadcast.
- Write to register 0 is forwarded unchanged; the register file ignores it.
- Width rules: grant_id width is log2(EX_NUM), minimum 1. rr_ptr wraps from EX_NUM-1 to 0.

Test Plan:
- Reset, then unit 2 sends data=0x0000_00AA, reg=5, tag=3 -> after 2 edges wb_valid=1, wd=0xAA, wr=5, w_tag=3, grant_id=2 for exactly one cycle, then w_tag=0.
- Units 0..3 all request in the same cycle, tags 1..4, rr_ptr=0 -> broadcasts occur on consecutive cycles in order tags 1,2,3,4, and rr_ptr ends at 0.
- Unit 1 streams tags 1..8 with valid held high, and unit 3 requests tag 9 at cycle 3 -> tag 9 is broadcast within 2 cycles of buffering. Unit 1 results keep order, with no gaps except the one slot given to unit 3.
- Buffer 0 is full and not granted (unit 1 has priority) -> req_ready[0]=0 and new data on unit 0 is held off. req_ready[0] rises in the grant cycle, and the refill is captured the same edge.
- Buffers hold tags 5 and 6 and flush pulses -> the next cycle has wb_valid=0 and w_tag=0, and tags 5 and 6 are never broadcast. A new request the following cycle broadcasts normally.
- Reset is asserted asynchronously between edges while wb_valid=1 -> outputs go to 0 immediately. After release, req_ready is all ones and rr_ptr=0.

Source files
------------

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Purpose  : Round-robin writeback (common data bus) arbiter. Each execution
//            unit feeds a one-entry holding buffer; one result per cycle is
//            broadcast through a registered output.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter  int EX_NUM = 4,
    parameter  int DATA_W = 32,
    parameter  int REG_W  = 5,
    parameter  int TAG_W  = 4,
    localparam int c_ID_W = (EX_NUM > 1) ? $clog2(EX_NUM) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [EX_NUM-1:0]        req_valid,
    output logic [EX_NUM-1:0]        req_ready,
    input  logic [EX_NUM*DATA_W-1:0] req_data,
    input  logic [EX_NUM*REG_W-1:0]  req_reg,
    input  logic [EX_NUM*TAG_W-1:0]  req_tag,
    output logic                     wb_valid,
    output logic [DATA_W-1:0]        wd,
    output logic [REG_W-1:0]         wr,
    output logic [TAG_W-1:0]         w_tag,
    output logic [c_ID_W-1:0]        grant_id
);

    logic [EX_NUM-1:0] r_buf_valid;
    logic [DATA_W-1:0] r_buf_data [EX_NUM];
    logic [REG_W-1:0]  r_buf_reg  [EX_NUM];
    logic [TAG_W-1:0]  r_buf_tag  [EX_NUM];
    logic [c_ID_W-1:0] r_rr_ptr;

    logic              r_wb_valid;
    logic [DATA_W-1:0] r_wd;
    logic [REG_W-1:0]  r_wr;
    logic [TAG_W-1:0]  r_w_tag;
    logic [c_ID_W-1:0] r_grant_id;

    logic [EX_NUM-1:0] w_grant;
    logic              w_grant_any;
    logic [c_ID_W-1:0] w_grant_idx;
    logic [c_ID_W-1:0] w_scan_idx;
    logic [c_ID_W-1:0] w_ptr_next;
    logic [EX_NUM-1:0] w_accept;

    // Scan from the round-robin pointer; the first valid buffer wins.
    always_comb begin
        w_grant     = '0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_scan_idx  = '0;
        for (int k = 0; k < EX_NUM; k++) begin
            w_scan_idx = c_ID_W'((32'(r_rr_ptr) + 32'(k)) % 32'(EX_NUM));
            if (!w_grant_any && r_buf_valid[w_scan_idx]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_scan_idx;
            end
        end
        if (w_grant_any) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    assign w_ptr_next = (w_grant_idx == c_ID_W'(EX_NUM - 1)) ? '0
                                                              : w_grant_idx + c_ID_W'(1);

    // A buffer being drained this cycle can take a new result on the same edge.
    always_comb begin
        req_ready = '0;
        w_accept  = '0;
        for (int i = 0; i < EX_NUM; i++) begin
            req_ready[i] = !flush && (!r_buf_valid[i] || w_grant[i]);
            w_accept[i]  = req_valid[i] && req_ready[i] &&
                           (req_tag[i*TAG_W +: TAG_W] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_valid <= '0;
            for (int i = 0; i < EX_NUM; i++) begin
                r_buf_data[i] <= '0;
                r_buf_reg[i]  <= '0;
                r_buf_tag[i]  <= '0;
            end
        end else if (flush) begin
            r_buf_valid <= '0;
        end else begin
            for (int i = 0; i < EX_NUM; i++) begin
                if (w_accept[i]) begin
                    r_buf_valid[i] <= 1'b1;
                    r_buf_data[i]  <= req_data[i*DATA_W +: DATA_W];
                    r_buf_reg[i]   <= req_reg[i*REG_W +: REG_W];
                    r_buf_tag[i]   <= req_tag[i*TAG_W +: TAG_W];
                end else if (w_grant[i]) begin
                    r_buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (!flush && w_grant_any) begin
            r_rr_ptr <= w_ptr_next;
        end
    end

    // Idle and flushed cycles drive an all-zero bus so tag 0 means "nothing".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wd       <= '0;
            r_wr       <= '0;
            r_w_tag    <= '0;
            r_grant_id <= '0;
        end else if (flush || !w_grant_any) begin
            r_wb_valid <= 1'b0;
            r_wd       <= '0;
            r_wr       <= '0;
            r_w_tag    <= '0;
            r_grant_id <= '0;
        end else begin
            r_wb_valid <= 1'b1;
            r_wd       <= r_buf_data[w_grant_idx];
            r_wr       <= r_buf_reg[w_grant_idx];
            r_w_tag    <= r_buf_tag[w_grant_idx];
            r_grant_id <= w_grant_idx;
        end
    end

    assign wb_valid = r_wb_valid;
    assign wd       = r_wd;
    assign wr       = r_wr;
    assign w_tag    = r_w_tag;
    assign grant_id = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Purpose  : Scoreboard bench for cdb_arbiter with a behavioural reference.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int TW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_data = '0;
    logic [N*RW-1:0] req_reg = '0;
    logic [N*TW-1:0] req_tag = '0;
    logic            wb_valid;
    logic [DW-1:0]   wd;
    logic [RW-1:0]   wr;
    logic [TW-1:0]   w_tag;
    logic [1:0]      grant_id;

    cdb_arbiter #(.EX_NUM(N), .DATA_W(DW), .REG_W(RW), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_reg(req_reg), .req_tag(req_tag),
        .wb_valid(wb_valid), .wd(wd), .wr(wr), .w_tag(w_tag), .grant_id(grant_id)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
        logic [RW-1:0] r;
        logic [TW-1:0] t;
        logic [1:0]    id;
    } bcast_t;

    int checks = 0;
    int errors = 0;
    bcast_t exp_q[$];

    // Reference: one pending result per unit plus a rotating priority start.
    logic          m_valid [N] = '{default: 1'b0};
    logic [DW-1:0] m_data  [N];
    logic [RW-1:0] m_reg   [N];
    logic [TW-1:0] m_tag   [N];
    int            m_ptr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_first();
        for (int k = 0; k < N; k++) begin
            if (m_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int g;
        g = model_first();
        for (int i = 0; i < N; i++) r[i] = !flush && (!m_valid[i] || g == i);
        return r;
    endfunction

    initial forever begin : model
        int     g;
        bcast_t e;
        logic [N-1:0] rdy;
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
            m_ptr = 0;
            exp_q.delete();
        end else begin
            g = model_first();
            e = '0;
            if (!flush && g >= 0) begin
                e.v  = 1'b1;
                e.d  = m_data[g];
                e.r  = m_reg[g];
                e.t  = m_tag[g];
                e.id = 2'(g);
            end
            exp_q.push_back(e);
            if (flush) begin
                for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
            end else begin
                for (int i = 0; i < N; i++) rdy[i] = !m_valid[i] || g == i;
                if (g >= 0) begin
                    m_valid[g] = 1'b0;
                    m_ptr = (g + 1) % N;
                end
                for (int i = 0; i < N; i++) begin
                    if (req_valid[i] && rdy[i] && req_tag[i*TW +: TW] != 0) begin
                        m_valid[i] = 1'b1;
                        m_data[i]  = req_data[i*DW +: DW];
                        m_reg[i]   = req_reg[i*RW +: RW];
                        m_tag[i]   = req_tag[i*TW +: TW];
                    end
                end
            end
        end
    end

    initial forever begin : monitor
        bcast_t e;
        @(negedge clk);
        if (rst) begin
            chk("reset_outputs", 64'({wb_valid, wd, wr, w_tag, grant_id}), 64'd0);
        end else begin
            e = (exp_q.size() == 0) ? bcast_t'(0) : exp_q.pop_front();
            chk("bcast", 64'({wb_valid, wd, wr, w_tag, grant_id}), 64'(e));
            chk("req_ready", 64'(req_ready), 64'(model_ready()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int u, input logic [DW-1:0] d,
                           input logic [RW-1:0] r, input logic [TW-1:0] t);
        req_valid[u]          = 1'b1;
        req_data[u*DW +: DW]  = d;
        req_reg[u*RW +: RW]   = r;
        req_tag[u*TW +: TW]   = t;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_data  = '0;
        req_reg   = '0;
        req_tag   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        clear_reqs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("ready_after_reset", 64'(req_ready), 64'hF);

        // Single request from unit 2.
        set_req(2, 32'h0000_00AA, 5'd5, 4'd3);
        tick();
        clear_reqs();
        tick();
        chk("t1_valid", 64'(wb_valid), 64'd1);
        chk("t1_wd", 64'(wd), 64'hAA);
        chk("t1_wr", 64'(wr), 64'd5);
        chk("t1_tag", 64'(w_tag), 64'd3);
        chk("t1_id", 64'(grant_id), 64'd2);
        tick();
        chk("t1_tag_after", 64'(w_tag), 64'd0);
        chk("t1_valid_after", 64'(wb_valid), 64'd0);

        // All four units at once: round-robin from pointer 0.
        do_reset();
        for (int u = 0; u < N; u++) set_req(u, 32'h100 + 32'(u), 5'(u + 1), 4'(u + 1));
        tick();
        clear_reqs();
        for (int k = 1; k <= N; k++) begin
            tick();
            chk("t2_tag_order", 64'(w_tag), 64'(k));
            chk("t2_id_order", 64'(grant_id), 64'(k - 1));
        end
        tick();
        chk("t2_idle", 64'(wb_valid), 64'd0);

        // Unit 1 streams tags 1..8, unit 3 injects tag 9 at cycle 3.
        do_reset();
        begin
            int t = 1;
            int c = 0;
            bit u3done = 1'b0;
            bit r1, r3, v3;
            while (t <= 8 && c < 60) begin
                set_req(1, $urandom, 5'($urandom_range(0, 31)), 4'(t));
                v3 = (c >= 3) && !u3done;
                if (v3) set_req(3, 32'hDEAD_0009, 5'd9, 4'd9);
                else req_valid[3] = 1'b0;
                #1;
                r1 = req_ready[1];
                r3 = req_ready[3];
                tick();
                if (r1) t++;
                if (v3 && r3) u3done = 1'b1;
                c++;
            end
            clear_reqs();
            repeat (4) tick();
            chk("t3_stream_done", 64'(t), 64'd9);
        end

        // Buffer 0 held off while unit 1 has priority, refilled in its grant cycle.
        do_reset();
        set_req(0, 32'h11, 5'd1, 4'd1);
        tick();
        clear_reqs();
        tick();
        set_req(0, 32'h22, 5'd2, 4'd2);
        set_req(1, 32'h33, 5'd3, 4'd3);
        tick();
        clear_reqs();
        set_req(0, 32'h44, 5'd4, 4'd4);
        #1;
        chk("t4_ready0_blocked", 64'(req_ready[0]), 64'd0);
        tick();
        chk("t4_tag_unit1", 64'(w_tag), 64'd3);
        chk("t4_ready0_grant", 64'(req_ready[0]), 64'd1);
        tick();
        clear_reqs();
        chk("t4_tag_old0", 64'(w_tag), 64'd2);
        tick();
        chk("t4_tag_refill", 64'(w_tag), 64'd4);

        // Flush discards buffered tags 5 and 6.
        do_reset();
        set_req(0, 32'h55, 5'd5, 4'd5);
        set_req(1, 32'h66, 5'd6, 4'd6);
        tick();
        clear_reqs();
        flush = 1'b1;
        #1;
        chk("t5_ready_flush", 64'(req_ready), 64'd0);
        tick();
        flush = 1'b0;
        chk("t5_valid_flush", 64'(wb_valid), 64'd0);
        chk("t5_tag_flush", 64'(w_tag), 64'd0);
        set_req(2, 32'h77, 5'd7, 4'd7);
        tick();
        clear_reqs();
        chk("t5_no_stale", 64'(w_tag), 64'd0);
        tick();
        chk("t5_new_tag", 64'(w_tag), 64'd7);

        // Illegal tag 0 is never loaded.
        set_req(3, 32'h99, 5'd9, 4'd0);
        tick();
        clear_reqs();
        tick();
        chk("tag0_ignored", 64'(wb_valid), 64'd0);

        // Asynchronous reset while a broadcast is on the bus.
        set_req(0, 32'h88, 5'd8, 4'd8);
        tick();
        clear_reqs();
        tick();
        chk("t6_bcast_live", 64'(wb_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_clear", 64'({wb_valid, wd, wr, w_tag, grant_id}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("t6_ready_ones", 64'(req_ready), 64'hF);
        set_req(0, 32'hA0, 5'd10, 4'd10);
        set_req(1, 32'hA1, 5'd11, 4'd11);
        tick();
        clear_reqs();
        tick();
        chk("t6_ptr_zero", 64'(grant_id), 64'd0);
        repeat (2) tick();

        // Randomized traffic with occasional flush and illegal tags.
        for (int c = 0; c < 400; c++) begin
            for (int u = 0; u < N; u++) begin
                if ($urandom_range(0, 99) < 45)
                    set_req(u, $urandom, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
                else
                    req_valid[u] = 1'b0;
            end
            flush = ($urandom_range(0, 31) == 0);
            tick();
        end
        clear_reqs();
        flush = 1'b0;
        repeat (N + 2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
